// File: rtl/serial_sub_pkg.sv
// Shared types for the bit-serial subtractor.
// The optional signed-overflow output is enabled by defining SERIAL_SUB_OVF_EN.
package serial_sub_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } sub_state_t;

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor: x - y - bin, giving difference d and borrow-out bo.
module full_subtractor (
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic d,
    output logic bo
);

    assign d  = x ^ y ^ bin;
    assign bo = (~x & y) | (~(x ^ y) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor (a - b, LSB first, one bit per clock).
// Define SERIAL_SUB_OVF_EN to add the signed 'overflow' output.
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
`ifdef SERIAL_SUB_OVF_EN
    output logic             overflow,
`endif
    output logic [1:0]       dbg_state_o
);

    localparam int CW = $clog2(WIDTH);

    // Handshake: a transfer happens on a rising clk edge where valid and ready are both 1;
    // valid-side outputs stay stable until that edge.

    sub_state_t       state_q;
    logic [WIDTH-1:0] a_sr_q, b_sr_q, res_q;
    logic [WIDTH-1:0] res_d;
    logic             bff_q, bff_d;
    logic [CW-1:0]    cnt_q;
    logic             in_ready_q, out_valid_q;
    logic             fs_d;

    full_subtractor u_fs (
        .x   (a_sr_q[0]),
        .y   (b_sr_q[0]),
        .bin (bff_q),
        .d   (fs_d),
        .bo  (bff_d)
    );

    assign res_d = {fs_d, res_q[WIDTH-1:1]};

`ifdef SERIAL_SUB_OVF_EN
    logic a_msb_q, b_msb_q, ovf_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            a_sr_q      <= '0;
            b_sr_q      <= '0;
            res_q       <= '0;
            bff_q       <= 1'b0;
            cnt_q       <= '0;
`ifdef SERIAL_SUB_OVF_EN
            a_msb_q     <= 1'b0;
            b_msb_q     <= 1'b0;
            ovf_q       <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        a_sr_q     <= a;
                        b_sr_q     <= b;
                        bff_q      <= 1'b0;
                        cnt_q      <= '0;
                        in_ready_q <= 1'b0;
                        state_q    <= SHIFT;
`ifdef SERIAL_SUB_OVF_EN
                        a_msb_q    <= a[WIDTH-1];
                        b_msb_q    <= b[WIDTH-1];
`endif
                    end
                end
                SHIFT: begin
                    res_q  <= res_d;
                    a_sr_q <= a_sr_q >> 1;
                    b_sr_q <= b_sr_q >> 1;
                    bff_q  <= bff_d;
                    cnt_q  <= cnt_q + 1'b1;
                    // The bit computed now is the MSB, so it is also the sign of diff.
                    if (cnt_q == CW'(WIDTH - 1)) begin
                        state_q     <= DONE;
                        out_valid_q <= 1'b1;
`ifdef SERIAL_SUB_OVF_EN
                        ovf_q       <= (a_msb_q != b_msb_q) & (fs_d != a_msb_q);
`endif
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
`ifdef SERIAL_SUB_OVF_EN
                        ovf_q       <= 1'b0;
`endif
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = out_valid_q;
    assign diff        = res_q;
    assign borrow      = bff_q;
    assign dbg_state_o = state_q;
`ifdef SERIAL_SUB_OVF_EN
    assign overflow    = ovf_q;
`endif

endmodule
